fsm_cmd_sequencer: RTL and testbench

//  Initiator for fsm16bit: replays a stored command program onto fsm16bit's

---
 rtl/fsm_seq_pkg.sv | 40 ++++
 rtl/fsm_cmd_rom.sv | 40 ++++
 rtl/fsm_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_fsm_cmd_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_pkg.sv
// Shared definitions for the fsm16bit command sequencer: state encoding,
// command-word field layout and the stored program's command words.
package fsm_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_FETCH,
        ST_SETUP,
        ST_PULSE,
        ST_GAP,
        ST_SETTLE,
        ST_DONE
    } seq_state_t;

    // Command word: [7] END, [6] check, [5] mode, [4] direction, [3:0] value
    localparam int CMD_W       = 8;
    localparam int CMD_END_BIT = 7;
    localparam int CMD_CHK_BIT = 6;
    localparam int CMD_MOD_BIT = 5;
    localparam int CMD_DIR_BIT = 4;
    localparam int CMD_VAL_MSB = 3;
    localparam int CMD_VAL_LSB = 0;

    localparam logic [CMD_W-1:0] CMD_END   = 8'hC0;
    localparam logic [CMD_W-1:0] CMD_ADD1  = 8'h71;
    localparam logic [CMD_W-1:0] CMD_ADD3  = 8'h73;
    localparam logic [CMD_W-1:0] CMD_SUB3  = 8'h63;
    localparam logic [CMD_W-1:0] CMD_SHL   = 8'h51;
    localparam logic [CMD_W-1:0] CMD_SHR   = 8'h41;
    localparam logic [CMD_W-1:0] CMD_NC_S0 = 8'h10;
    localparam logic [CMD_W-1:0] CMD_NC_SL = 8'h11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fsm_cmd_rom.sv
// Synchronous-read program ROM holding the default fsm16bit exercise program.
// Addresses beyond the table read back as END.
module fsm_cmd_rom
    import fsm_seq_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic                 i_clock,
    input  logic [IDX_W-1:0]     i_addr,
    output logic [CMD_W-1:0]     o_data
);

    logic [7:0]       w_addr;
    logic [CMD_W-1:0] w_word;
    logic [CMD_W-1:0] r_data;

    assign w_addr = 8'(i_addr);

    always_comb begin
        w_word = CMD_END;
        unique case (w_addr)
            8'd0, 8'd1, 8'd2, 8'd3: w_word = CMD_ADD1;
            8'd4:                   w_word = CMD_ADD3;
            8'd5, 8'd6:             w_word = CMD_SUB3;
            8'd7, 8'd8:             w_word = CMD_SHL;
            8'd9, 8'd10, 8'd11:     w_word = CMD_SHR;
            8'd12, 8'd13:           w_word = CMD_SHL;
            8'd14:                  w_word = CMD_NC_S0;
            8'd15:                  w_word = CMD_NC_SL;
            default:                w_word = CMD_END;
        endcase
    end

    always_ff @(posedge i_clock) begin
        r_data <= w_word;
    end

    assign o_data = r_data;

endmodule

// File: rtl/fsm_cmd_sequencer.sv
// Replays the ROM program onto fsm16bit's control inputs and compares the
// returned count against EXPECT once the program has settled.
module fsm_cmd_sequencer
    import fsm_seq_pkg::*;
#(
    parameter int          ROM_DEPTH     = 32,
    parameter int          SETUP_CYCLES  = 1,
    parameter int          GAP_CYCLES    = 1,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECT        = 16'd3872
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [15:0]                  i_fsm_count,
    output logic                         o_fsm_reset,
    output logic                         o_fsm_enable,
    output logic                         o_fsm_check,
    output logic                         o_fsm_mode,
    output logic                         o_fsm_direction,
    output logic [3:0]                   o_fsm_value,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_pass,
    output logic                         o_overrun,
    output logic [$clog2(ROM_DEPTH)-1:0] o_cmd_index,
    output seq_state_t                   o_dbg_state
);

    localparam int IDX_W    = $clog2(ROM_DEPTH);
    localparam int MAX_WAIT = max3(SETUP_CYCLES, GAP_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROM_DEPTH - 1);

    seq_state_t       r_state;
    seq_state_t       w_state_next;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_next;
    logic [IDX_W-1:0] w_rom_addr;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CMD_W-1:0] w_rom_data;
    logic             r_check;
    logic             r_mode;
    logic             r_dir;
    logic [3:0]       r_value;
    logic             r_pass;
    logic             r_overrun;
    logic             w_load_ops;
    logic             w_clear;
    logic             w_set_overrun;
    logic             w_capture;

    // The ROM is one cycle late, so the next index is presented during GAP
    // and the first index (already cleared to 0) during RST.
    assign w_rom_addr = (r_state == ST_GAP) ? r_index + 1'b1 : r_index;

    fsm_cmd_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .i_clock (i_clock),
        .i_addr  (w_rom_addr),
        .o_data  (w_rom_data)
    );

    always_comb begin
        w_state_next  = r_state;
        w_index_next  = r_index;
        w_cnt_next    = (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
        w_load_ops    = 1'b0;
        w_clear       = 1'b0;
        w_set_overrun = 1'b0;
        w_capture     = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                // start is a level, sampled only here; done stays high until it is seen
                if (i_start) begin
                    w_state_next = ST_RST;
                    w_index_next = '0;
                    w_clear      = 1'b1;
                end
            end
            ST_RST: w_state_next = ST_FETCH;
            ST_FETCH: begin
                if (w_rom_data[CMD_END_BIT]) begin
                    w_state_next = ST_SETTLE;
                    w_cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    w_state_next = ST_SETUP;
                    w_cnt_next   = CNT_W'(SETUP_CYCLES - 1);
                    w_load_ops   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) w_state_next = ST_PULSE;
            end
            ST_PULSE: begin
                w_state_next = ST_GAP;
                w_cnt_next   = CNT_W'(GAP_CYCLES - 1);
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    if (r_index == LAST_IDX) begin
                        w_set_overrun = 1'b1;
                        w_state_next  = ST_SETTLE;
                        w_cnt_next    = CNT_W'(SETTLE_CYCLES - 1);
                    end else begin
                        w_index_next = r_index + 1'b1;
                        w_state_next = ST_FETCH;
                    end
                end
            end
            ST_SETTLE: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_index   <= '0;
            r_cnt     <= '0;
            r_check   <= 1'b1;
            r_mode    <= 1'b0;
            r_dir     <= 1'b0;
            r_value   <= '0;
            r_pass    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_cnt   <= w_cnt_next;
            if (w_load_ops) begin
                r_check <= w_rom_data[CMD_CHK_BIT];
                r_mode  <= w_rom_data[CMD_MOD_BIT];
                r_dir   <= w_rom_data[CMD_DIR_BIT];
                r_value <= w_rom_data[CMD_VAL_MSB:CMD_VAL_LSB];
            end
            if (w_clear) begin
                r_pass    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_set_overrun) r_overrun <= 1'b1;
            if (w_capture)     r_pass    <= (i_fsm_count == EXPECT);
        end
    end

    assign o_fsm_reset     = (r_state == ST_RST);
    assign o_fsm_enable    = (r_state == ST_PULSE);
    assign o_fsm_check     = r_check;
    assign o_fsm_mode      = r_mode;
    assign o_fsm_direction = r_dir;
    assign o_fsm_value     = r_value;
    assign o_busy          = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign o_done          = (r_state == ST_DONE);
    assign o_pass          = r_pass;
    assign o_overrun       = r_overrun;
    assign o_cmd_index     = r_index;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_fsm_cmd_sequencer.sv
// Bench for fsm_cmd_sequencer: default 32-entry program and a 4-entry
// program without END, checked against a timing/program model.
module tb_fsm_cmd_sequencer;
  import fsm_seq_pkg::*;

  localparam logic [15:0] EXPECT = 16'd3872;
  localparam int PERIOD = 4;
  localparam int FIRST_PULSE = 3;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b;
  logic [15:0] fsm_count;

  logic a_freset, a_enable, a_check, a_mode, a_dir, a_busy, a_done, a_pass, a_overrun;
  logic [3:0] a_value;
  logic [4:0] a_index;
  seq_state_t a_state;
  logic b_freset, b_enable, b_check, b_mode, b_dir, b_busy, b_done, b_pass, b_overrun;
  logic [3:0] b_value;
  logic [1:0] b_index;
  seq_state_t b_state;

  int n_checks = 0;
  int n_errors = 0;
  int cur_sel = 0;
  logic [7:0] prog_q[$];
  logic [6:0] exp_q[$];

  fsm_cmd_sequencer dut_a (
    .i_clock(clk), .i_reset(rst), .i_start(start_a), .i_fsm_count(fsm_count),
    .o_fsm_reset(a_freset), .o_fsm_enable(a_enable), .o_fsm_check(a_check),
    .o_fsm_mode(a_mode), .o_fsm_direction(a_dir), .o_fsm_value(a_value),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_overrun(a_overrun),
    .o_cmd_index(a_index), .o_dbg_state(a_state)
  );

  fsm_cmd_sequencer #(.ROM_DEPTH(4)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_start(start_b), .i_fsm_count(fsm_count),
    .o_fsm_reset(b_freset), .o_fsm_enable(b_enable), .o_fsm_check(b_check),
    .o_fsm_mode(b_mode), .o_fsm_direction(b_dir), .o_fsm_value(b_value),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_overrun(b_overrun),
    .o_cmd_index(b_index), .o_dbg_state(b_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  // monitor view of the DUT selected by cur_sel
  logic m_freset, m_enable, m_busy, m_done, m_pass, m_overrun;
  logic [6:0] m_ops;
  logic [4:0] m_index;
  assign m_freset  = (cur_sel == 1) ? b_freset  : a_freset;
  assign m_enable  = (cur_sel == 1) ? b_enable  : a_enable;
  assign m_busy    = (cur_sel == 1) ? b_busy    : a_busy;
  assign m_done    = (cur_sel == 1) ? b_done    : a_done;
  assign m_pass    = (cur_sel == 1) ? b_pass    : a_pass;
  assign m_overrun = (cur_sel == 1) ? b_overrun : a_overrun;
  assign m_ops     = (cur_sel == 1) ? {b_check, b_mode, b_dir, b_value}
                                    : {a_check, a_mode, a_dir, a_value};
  assign m_index   = (cur_sel == 1) ? {3'b000, b_index} : a_index;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_cmd(input logic chk, input logic mode, input logic dir,
                         input logic [3:0] val, input int n);
    for (int i = 0; i < n; i++) prog_q.push_back({1'b0, chk, mode, dir, val});
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start_b = v;
    else start_a = v;
  endtask

  // One run from IDLE/DONE; expected pulses come from the program list and
  // the timing from the fixed command period.
  task automatic run_and_check(input int sel, input logic [15:0] final_count, input bit noisy);
    int depth, n_exp, done_off, exp_idx, pulses, hold;
    bit ovr_exp, seen_done, after_pulse;
    logic [6:0] prev_ops, pulse_ops, exp_ops;
    logic exp_pass;

    depth = (sel == 1) ? 4 : 32;
    exp_q.delete();
    ovr_exp = 1'b1;
    for (int i = 0; i < depth; i++) begin
      if (prog_q[i][7]) begin
        ovr_exp = 1'b0;
        break;
      end
      exp_q.push_back(prog_q[i][6:0]);
    end
    n_exp = exp_q.size();
    done_off = 1 + PERIOD * n_exp + (ovr_exp ? 0 : 1) + SETTLE;
    exp_idx = ovr_exp ? depth - 1 : n_exp;
    exp_pass = (final_count == EXPECT);

    cur_sel = sel;
    hold = $urandom_range(1, 4);
    fsm_count = 16'($urandom);
    set_start(sel, 1'b1);
    seen_done = 1'b0;
    after_pulse = 1'b0;
    pulses = 0;
    prev_ops = m_ops;
    pulse_ops = '0;

    for (int off = 0; off < done_off + 6; off++) begin
      step();
      if (off == 0) begin
        check("rst_at_start", m_freset, 1);
        check("busy_at_start", m_busy, 1);
        check("pass_cleared", m_pass, 0);
        check("overrun_cleared", m_overrun, 0);
      end else if (m_freset) begin
        check("rst_extra_off", off, 0);
      end
      if (m_enable) begin
        if (exp_q.size() == 0) begin
          check("extra_pulse", pulses, n_exp);
        end else begin
          exp_ops = exp_q.pop_front();
          check("pulse_ops", m_ops, exp_ops);
          check("pulse_off", off, FIRST_PULSE + PERIOD * pulses);
          check("ops_before_pulse", m_ops, prev_ops);
        end
        pulses++;
        after_pulse = 1'b1;
        pulse_ops = m_ops;
      end else if (after_pulse) begin
        check("ops_after_pulse", m_ops, pulse_ops);
        after_pulse = 1'b0;
      end
      if (m_done) begin
        seen_done = 1'b1;
        check("done_off", off, done_off);
        check("done_busy", m_busy, 0);
        check("done_pass", m_pass, exp_pass);
        check("done_overrun", m_overrun, ovr_exp);
        check("done_index", m_index, exp_idx);
      end
      prev_ops = m_ops;
      if (off < hold - 1) set_start(sel, 1'b1);
      else if (noisy && off < done_off - 9) set_start(sel, 1'($urandom_range(0, 1)));
      else set_start(sel, 1'b0);
      if (off < done_off - 8) fsm_count = 16'($urandom);
      else fsm_count = final_count;
      if (seen_done) break;
    end
    check("done_seen", seen_done, 1);
    check("pulse_count", pulses, n_exp);
  endtask

  task automatic reset_mid_pulse();
    int k, seen;
    bit hit;
    cur_sel = 0;
    k = $urandom_range(1, 15);
    seen = 0;
    hit = 1'b0;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (a_enable) begin
        if (seen == k) begin
          hit = 1'b1;
          break;
        end
        seen++;
      end
      step();
    end
    check("pulse_reached", hit, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_enable", a_enable, 0);
    check("midrst_busy", a_busy, 0);
    check("midrst_index", a_index, 0);
    check("midrst_state", a_state, ST_IDLE);
  endtask

  initial begin
    int sel;
    logic [15:0] cnt;

    add_cmd(1'b1, 1'b1, 1'b1, 4'd1, 4);
    add_cmd(1'b1, 1'b1, 1'b1, 4'd3, 1);
    add_cmd(1'b1, 1'b1, 1'b0, 4'd3, 2);
    add_cmd(1'b1, 1'b0, 1'b1, 4'd1, 2);
    add_cmd(1'b1, 1'b0, 1'b0, 4'd1, 3);
    add_cmd(1'b1, 1'b0, 1'b1, 4'd1, 2);
    add_cmd(1'b0, 1'b0, 1'b1, 4'd0, 1);
    add_cmd(1'b0, 1'b0, 1'b1, 4'd1, 1);
    while (prog_q.size() < 32) prog_q.push_back(8'h80);

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    fsm_count = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_fsm_reset", a_freset, 0);
    check("rst_enable", a_enable, 0);
    check("rst_check", a_check, 1);
    check("rst_operands", {a_mode, a_dir, a_value}, 0);
    check("rst_busy_done", {a_busy, a_done}, 0);
    check("rst_pass_ovr", {a_pass, a_overrun}, 0);
    check("rst_index", a_index, 0);
    check("rst_state", a_state, ST_IDLE);
    check("rst_b_idle", {b_busy, b_done, b_enable, b_check}, 4'b0001);

    run_and_check(0, EXPECT, 1'b0);
    run_and_check(0, EXPECT - 16'd1, 1'b0);
    run_and_check(0, EXPECT, 1'b1);

    run_and_check(1, 16'($urandom), 1'b0);
    cur_sel = 1;
    sel = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (b_enable) sel++;
    end
    check("no_fifth_pulse", sel, 0);
    check("ovr_done_held", {b_done, b_overrun}, 2'b11);
    check("ovr_index_held", b_index, 3);
    run_and_check(1, EXPECT, 1'b1);

    reset_mid_pulse();
    run_and_check(0, EXPECT, 1'b1);

    for (int r = 0; r < 5; r++) begin
      sel = $urandom_range(0, 1);
      case ($urandom_range(0, 2))
        0: cnt = EXPECT;
        1: cnt = EXPECT - 16'd1;
        default: cnt = 16'($urandom);
      endcase
      run_and_check(sel, cnt, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
